// File: rtl/seq_ctrl_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_ctrl_pkg
// Brief    : Shared types and constants for the push-button sequence
//            controller: state encoding, per-state LED patterns and switch
//            bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package seq_ctrl_pkg;

   // Encoding is the value driven on the STATE pins.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_READY   = 3'd2,
      ST_ARM     = 3'd3,
      ST_RUN     = 3'd4,
      ST_LOCK    = 3'd5,
      ST_CONFIRM = 3'd6,
      ST_DONE    = 3'd7
   } state_e;

   localparam logic [3:0] LED_IDLE    = 4'b0000;
   localparam logic [3:0] LED_START   = 4'b0001;
   localparam logic [3:0] LED_READY   = 4'b0011;
   localparam logic [3:0] LED_ARM     = 4'b0011;
   localparam logic [3:0] LED_RUN     = 4'b0111;
   localparam logic [3:0] LED_LOCK    = 4'b1011;
   localparam logic [3:0] LED_CONFIRM = 4'b1011;
   localparam logic [3:0] LED_DONE    = 4'b0000;

   // Bit positions within the active-low switch bus.
   localparam int SW_CONFIRM = 0;
   localparam int SW_A       = 1;
   localparam int SW_B       = 2;
   localparam int SW_START   = 3;

endpackage : seq_ctrl_pkg
`default_nettype wire

// File: rtl/seq_ctrl_param_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_ctrl_param_if
// Brief    : Switch-in / LED-out bundle between the debouncer side (master)
//            and the sequence controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface seq_ctrl_param_if #(
   parameter int CNT_W = 16
);
   logic [3:0]       switch_n;   // debounced switches, 0 = pressed
   logic [3:0]       led;        // LED pattern
   logic [2:0]       state;      // current state encoding
   logic [CNT_W-1:0] remain;     // remaining dwell ticks minus one
   logic             tick;       // one-clock pulse per tick

   modport master (
      output switch_n,
      input  led, state, remain, tick
   );

   modport slave (
      input  switch_n,
      output led, state, remain, tick
   );
endinterface : seq_ctrl_param_if
`default_nettype wire

// File: rtl/seq_ctrl_param_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Brief    : Modulo-DIV prescaler. tick_o is high for exactly one clock in
//            every DIV; the first pulse ends on the DIV-th edge after reset.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
   parameter int DIV = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   output logic tick_o
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   logic [PW-1:0] pre_q;

   // Free-running prescaler, wraps after DIV clocks.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pre_q <= '0;
      end else if (pre_q == PRE_LAST) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PW'(1);
      end
   end

   assign tick_o = (pre_q == PRE_LAST);

endmodule : tick_gen
`default_nettype wire

// File: rtl/seq_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_ctrl_param
// Brief    : Tick-driven 8-state LED sequence controller with edge-detected
//            presses, exact dwell counts, both-held lock and hold-to-abort.
// Revision : 1.0 - initial release
// ============================================================================
module seq_ctrl_param
   import seq_ctrl_pkg::*;
#(
   parameter int CLK_HZ  = 12_000_000,
   parameter int TICK_HZ = 1000,
   parameter int CNT_W   = 16,
   parameter int T_START = 2000,
   parameter int T_ARM   = 1000,
   parameter int T_RUN   = 5000,
   parameter int T_ABORT = 1500
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   seq_ctrl_param_if.slave  bus
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

   localparam logic [CNT_W-1:0] LD_START   = CNT_W'(T_START - 1);
   localparam logic [CNT_W-1:0] LD_ARM     = CNT_W'(T_ARM - 1);
   localparam logic [CNT_W-1:0] LD_RUN     = CNT_W'(T_RUN - 1);
   localparam logic [CNT_W-1:0] ABORT_LAST = CNT_W'(T_ABORT - 1);

   // Reject parameter sets the counters cannot represent.
   generate
      if ((DIV < 2) || ((CLK_HZ % TICK_HZ) != 0)) begin : g_bad_div
         $error("seq_ctrl_param: CLK_HZ/TICK_HZ must be an integer >= 2");
      end
      if ((T_START < 1) || (T_ARM < 1) || (T_RUN < 1) || (T_ABORT < 1)) begin : g_bad_tmin
         $error("seq_ctrl_param: all T_* values must be >= 1");
      end
      if ((64'(T_START) >= CNT_LIM) || (64'(T_ARM) >= CNT_LIM) ||
          (64'(T_RUN) >= CNT_LIM) || (64'(T_ABORT) >= CNT_LIM)) begin : g_bad_tmax
         $error("seq_ctrl_param: a T_* value does not fit in CNT_W bits");
      end
   endgenerate

   logic             tick;
   logic [3:0]       prev_q;
   logic             seen_q;
   logic [3:0]       press;
   logic             both_ab;
   logic             abort_hold;
   logic             abort_fire;
   state_e           state_q;
   logic [3:0]       led_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] acnt_q;
   logic [CNT_W-1:0] acnt_d;

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .tick_o  (tick)
   );

   // Sample the switches once per tick for falling-edge detection.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prev_q <= 4'b1111;
         seen_q <= 1'b0;
      end else if (tick) begin
         prev_q <= bus.switch_n;
         seen_q <= 1'b1;
      end
   end

   // A press needs a real released sample first, so a switch held through
   // reset never looks like a fresh press on the first tick.
   assign press      = seen_q ? (prev_q & ~bus.switch_n) : 4'b0000;
   assign both_ab    = ~bus.switch_n[SW_A] & ~bus.switch_n[SW_B];
   assign abort_hold = ~bus.switch_n[SW_CONFIRM] & ~bus.switch_n[SW_START];
   assign abort_fire = (state_q != ST_IDLE) && abort_hold && (acnt_q == ABORT_LAST);

   // Abort hold counter: counts held ticks, cleared on release, abort or IDLE.
   always_comb begin
      acnt_d = acnt_q;
      if ((state_q == ST_IDLE) || !abort_hold || abort_fire) begin
         acnt_d = '0;
      end else begin
         acnt_d = acnt_q + CNT_W'(1);
      end
   end

   // Main sequencer: state, LED pattern and dwell counter, all on tick edges.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         led_q   <= LED_IDLE;
         cnt_q   <= '0;
         acnt_q  <= '0;
      end else if (tick) begin
         acnt_q <= acnt_d;
         if (abort_fire) begin
            state_q <= ST_IDLE;
            led_q   <= LED_IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (press[SW_START]) begin
                     state_q <= ST_START;
                     led_q   <= LED_START;
                     cnt_q   <= LD_START;
                  end
               end
               ST_START: begin
                  if (cnt_q == '0) begin
                     state_q <= ST_READY;
                     led_q   <= LED_READY;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               ST_READY: begin
                  if (both_ab) begin
                     state_q <= ST_LOCK;
                     led_q   <= LED_LOCK;
                     cnt_q   <= '0;
                  end else if (press[SW_A] || press[SW_B]) begin
                     state_q <= ST_ARM;
                     led_q   <= LED_ARM;
                     cnt_q   <= LD_ARM;
                  end
               end
               ST_ARM: begin
                  if (both_ab) begin
                     state_q <= ST_LOCK;
                     led_q   <= LED_LOCK;
                     cnt_q   <= '0;
                  end else if (cnt_q == '0) begin
                     state_q <= ST_RUN;
                     led_q   <= LED_RUN;
                     cnt_q   <= LD_RUN;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               ST_RUN: begin
                  if (both_ab) begin
                     state_q <= ST_LOCK;
                     led_q   <= LED_LOCK;
                     cnt_q   <= '0;
                  end else if (cnt_q == '0) begin
                     state_q <= ST_DONE;
                     led_q   <= LED_DONE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               ST_LOCK: begin
                  if (press[SW_CONFIRM]) begin
                     state_q <= ST_CONFIRM;
                     led_q   <= LED_CONFIRM;
                     cnt_q   <= '0;
                  end
               end
               ST_CONFIRM: begin
                  if (press[SW_START]) begin
                     state_q <= ST_DONE;
                     led_q   <= LED_DONE;
                     cnt_q   <= '0;
                  end
               end
               ST_DONE: begin
                  if (press[SW_CONFIRM]) begin
                     state_q <= ST_IDLE;
                     led_q   <= LED_IDLE;
                     cnt_q   <= '0;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  led_q   <= LED_IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.state  = state_q;
   assign bus.led    = led_q;
   assign bus.remain = cnt_q;
   assign bus.tick   = tick;

endmodule : seq_ctrl_param
`default_nettype wire

// File: tb/tb_seq_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_ctrl_param
// Brief    : Self-checking bench for seq_ctrl_param with a tick-level
//            behavioural model (time-in-state and hold-length bookkeeping).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl_param;

   localparam int CLK_HZ  = 4;
   localparam int TICK_HZ = 1;
   localparam int DIV     = CLK_HZ / TICK_HZ;
   localparam int CNT_W   = 16;
   localparam int T_START = 3;
   localparam int T_ARM   = 2;
   localparam int T_RUN   = 4;
   localparam int T_ABORT = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   seq_ctrl_param_if #(.CNT_W(CNT_W)) bus ();

   seq_ctrl_param #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ),
      .CNT_W   (CNT_W),
      .T_START (T_START),
      .T_ARM   (T_ARM),
      .T_RUN   (T_RUN),
      .T_ABORT (T_ABORT)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (one call per tick) ----------------
   int         m_state;     // 0..7 as listed in the state table
   int         m_age;       // ticks spent in the current state
   int         m_hold;      // consecutive ticks with SW0 and SW3 both low
   logic [3:0] m_prev;
   bit         m_have_prev;

   function automatic logic [3:0] led_of(input int s);
      case (s)
         1:       return 4'b0001;
         2, 3:    return 4'b0011;
         4:       return 4'b0111;
         5, 6:    return 4'b1011;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic int dwell_of(input int s);
      case (s)
         1:       return T_START;
         3:       return T_ARM;
         4:       return T_RUN;
         default: return 0;
      endcase
   endfunction

   function automatic int remain_of();
      int d;
      d = dwell_of(m_state);
      return (d == 0) ? 0 : (d - 1 - m_age);
   endfunction

   task automatic model_reset();
      m_state     = 0;
      m_age       = 0;
      m_hold      = 0;
      m_prev      = 4'b1111;
      m_have_prev = 1'b0;
   endtask

   task automatic model_tick(input logic [3:0] sw);
      logic [3:0] pr;
      int  nxt;
      bit  abort;
      bit  lock;
      bit  expired;
      pr    = m_have_prev ? (m_prev & ~sw) : 4'b0000;
      nxt   = m_state;
      abort = 1'b0;
      if (m_state == 0) begin
         m_hold = 0;
      end else if (!sw[0] && !sw[3]) begin
         m_hold = m_hold + 1;
         if (m_hold == T_ABORT) abort = 1'b1;
      end else begin
         m_hold = 0;
      end
      if (abort) begin
         nxt    = 0;
         m_hold = 0;
      end else begin
         lock    = !sw[1] && !sw[2];
         expired = (dwell_of(m_state) != 0) && (m_age + 1 >= dwell_of(m_state));
         case (m_state)
            0: if (pr[3]) nxt = 1;
            1: if (expired) nxt = 2;
            2: if (lock) nxt = 5; else if (pr[1] || pr[2]) nxt = 3;
            3: if (lock) nxt = 5; else if (expired) nxt = 4;
            4: if (lock) nxt = 5; else if (expired) nxt = 7;
            5: if (pr[0]) nxt = 6;
            6: if (pr[3]) nxt = 7;
            7: if (pr[0]) nxt = 0;
            default: nxt = 0;
         endcase
      end
      if (nxt != m_state) m_age = 0;
      else                m_age = m_age + 1;
      m_state     = nxt;
      m_prev      = sw;
      m_have_prev = 1'b1;
   endtask

   // Apply a switch vector, run to the next tick edge, update the model and
   // leave time 1 unit after that edge for sampling.
   task automatic step(input logic [3:0] sw);
      bit got;
      got = 1'b0;
      bus.switch_n = sw;
      for (int i = 0; i < 3 * DIV && !got; i++) begin
         @(negedge clk);
         if (bus.tick === 1'b1) begin
            @(posedge clk);
            got = 1'b1;
         end
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL tick_timeout: got no tick within %0d cycles, want one every %0d", 3 * DIV, DIV);
      end
      model_tick(sw);
      #1;
   endtask

   // ------------------------------ tests ------------------------------
   task automatic test_reset();
      int c;
      model_reset();
      bus.switch_n = 4'b0111;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (bus.state !== 3'd0 || bus.led !== 4'b0000 || bus.remain !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got state %0d led %b remain %0d, want 0 0000 0", bus.state, bus.led, bus.remain);
      end
      n_tests++;
      if (bus.tick !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tick: got %b want 0", bus.tick);
      end
      @(negedge clk);
      rst_n = 1'b1;
      c = 0;
      while (c < 3 * DIV) begin
         c++;
         @(negedge clk);
         if (bus.tick === 1'b1) break;
      end
      n_tests++;
      if (c != DIV - 1) begin
         n_fail++;
         $display("FAIL first_tick: tick seen at cycle %0d after release, want %0d", c + 1, DIV);
      end
      @(posedge clk);
      model_tick(4'b0111);
      #1;
      n_tests++;
      if (bus.state !== 3'd0 || bus.led !== 4'b0000) begin
         n_fail++;
         $display("FAIL held_through_reset: got state %0d led %b want 0 0000", bus.state, bus.led);
      end
      n_tests++;
      if (bus.tick !== 1'b0) begin
         n_fail++;
         $display("FAIL tick_width: tick still %b one clock after tick edge, want 0", bus.tick);
      end
      step(4'b0111);
      step(4'b1111);
      n_tests++;
      if (bus.state !== 3'd0) begin
         n_fail++;
         $display("FAIL held_no_repeat: got state %0d want 0", bus.state);
      end
      step(4'b0111);
      n_tests++;
      if (bus.state !== 3'd1 || bus.led !== 4'b0001 || bus.remain !== CNT_W'(2)) begin
         n_fail++;
         $display("FAIL start_press: got state %0d led %b remain %0d, want 1 0001 2", bus.state, bus.led, bus.remain);
      end
   endtask

   task automatic test_timed_path();
      logic [3:0] sw [11];
      int st [11] = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 4, 7};
      int rm [11] = '{1, 0, 0, 0, 1, 0, 3, 2, 1, 0, 0};
      logic [1:0] ab;
      for (int i = 0; i < 3; i++) sw[i] = {1'b1, 3'($urandom_range(0, 7))};
      sw[3] = 4'b1111;
      sw[4] = 4'b1101;
      sw[5] = 4'b1101;
      sw[6] = 4'b1101;
      for (int i = 7; i < 11; i++) begin
         ab    = 2'($urandom_range(1, 3));
         sw[i] = {1'b1, ab, 1'($urandom_range(0, 1))};
      end
      for (int i = 0; i < 11; i++) begin
         step(sw[i]);
         n_tests++;
         if (bus.state !== 3'(st[i]) || bus.led !== led_of(st[i]) || bus.remain !== CNT_W'(rm[i])) begin
            n_fail++;
            $display("FAIL timed_path step %0d: got state %0d led %b remain %0d, want %0d %b %0d",
                     i, bus.state, bus.led, bus.remain, st[i], led_of(st[i]), rm[i]);
         end
      end
   endtask

   task automatic test_lock_priority();
      logic [3:0] sw [10] = '{4'b1111, 4'b1110, 4'b1111, 4'b0111, 4'b1111,
                              4'b1111, 4'b1111, 4'b1011, 4'b1011, 4'b1001};
      int st [10] = '{7, 0, 0, 1, 1, 1, 2, 3, 3, 5};
      int rm [10] = '{0, 0, 0, 2, 1, 0, 0, 1, 0, 0};
      for (int i = 0; i < 10; i++) begin
         step(sw[i]);
         n_tests++;
         if (bus.state !== 3'(st[i]) || bus.led !== led_of(st[i]) || bus.remain !== CNT_W'(rm[i])) begin
            n_fail++;
            $display("FAIL lock_priority step %0d: got state %0d led %b remain %0d, want %0d %b %0d",
                     i, bus.state, bus.led, bus.remain, st[i], led_of(st[i]), rm[i]);
         end
      end
   endtask

   task automatic test_lock_exit();
      logic [3:0] sw [7] = '{4'b1110, 4'b1110, 4'b1111, 4'b0111, 4'b0111, 4'b1110, 4'b1110};
      int st [7] = '{6, 6, 6, 7, 7, 0, 0};
      for (int i = 0; i < 7; i++) begin
         step(sw[i]);
         n_tests++;
         if (bus.state !== 3'(st[i]) || bus.led !== led_of(st[i]) || bus.remain !== '0) begin
            n_fail++;
            $display("FAIL lock_exit step %0d: got state %0d led %b remain %0d, want %0d %b 0",
                     i, bus.state, bus.led, bus.remain, st[i], led_of(st[i]));
         end
      end
   endtask

   task automatic test_abort();
      logic [3:0] sw_a [11] = '{4'b1111, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1101,
                                4'b1111, 4'b1111, 4'b0110, 4'b0110, 4'b0110};
      int st_a [11] = '{0, 1, 1, 1, 2, 3, 3, 4, 4, 4, 0};
      int rm_a [11] = '{0, 2, 1, 0, 0, 1, 0, 3, 2, 1, 0};
      logic [3:0] sw_b [11] = '{4'b1111, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b0110,
                                4'b0110, 4'b1111, 4'b0110, 4'b0110, 4'b0110};
      int st_b [11] = '{0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 0};
      int rm_b [11] = '{0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 11; i++) begin
         step(sw_a[i]);
         n_tests++;
         if (bus.state !== 3'(st_a[i]) || bus.led !== led_of(st_a[i]) || bus.remain !== CNT_W'(rm_a[i])) begin
            n_fail++;
            $display("FAIL abort_run step %0d: got state %0d led %b remain %0d, want %0d %b %0d",
                     i, bus.state, bus.led, bus.remain, st_a[i], led_of(st_a[i]), rm_a[i]);
         end
      end
      for (int i = 0; i < 11; i++) begin
         step(sw_b[i]);
         n_tests++;
         if (bus.state !== 3'(st_b[i]) || bus.led !== led_of(st_b[i]) || bus.remain !== CNT_W'(rm_b[i])) begin
            n_fail++;
            $display("FAIL abort_release step %0d: got state %0d led %b remain %0d, want %0d %b %0d",
                     i, bus.state, bus.led, bus.remain, st_b[i], led_of(st_b[i]), rm_b[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [3:0] sw [9] = '{4'b1111, 4'b0111, 4'b1111, 4'b1111, 4'b1111,
                             4'b1101, 4'b1111, 4'b1111, 4'b1111};
      for (int i = 0; i < 9; i++) step(sw[i]);
      n_tests++;
      if (bus.state !== 3'd4 || bus.remain !== CNT_W'(2)) begin
         n_fail++;
         $display("FAIL async_setup: got state %0d remain %0d, want 4 2", bus.state, bus.remain);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.state !== 3'd0 || bus.led !== 4'b0000 || bus.remain !== '0 || bus.tick !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got state %0d led %b remain %0d tick %b, want 0 0000 0 0",
                  bus.state, bus.led, bus.remain, bus.tick);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [3:0] sw;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            sw = 4'b1111;
         end else begin
            for (int b = 0; b < 4; b++) sw[b] = ($urandom_range(0, 2) != 0);
         end
         step(sw);
         n_tests++;
         if (bus.state !== 3'(m_state) || bus.led !== led_of(m_state) || bus.remain !== CNT_W'(remain_of())) begin
            n_fail++;
            $display("FAIL random tick %0d sw %b: got state %0d led %b remain %0d, want %0d %b %0d",
                     n, sw, bus.state, bus.led, bus.remain, m_state, led_of(m_state), remain_of());
         end
      end
   endtask

   initial begin
      bus.switch_n = 4'b0111;
      test_reset();
      test_timed_path();
      test_lock_priority();
      test_lock_exit();
      test_abort();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, want it finished");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_seq_ctrl_param
`default_nettype wire

// File: doc/seq_ctrl_param.md
# seq_ctrl_param

Parametrised successor of the board's push-button sequence controller. It generates its own tick from CLK and runs an 8-state LED sequence, advancing on debounced, active-low switch presses and on programmable tick delays. Compared with the earlier controller it adds:
- edge-detected presses;
- tick-exact dwell times;
- a hold-to-abort escape;
- a visible countdown and state.

It sits between the switch debouncer and the LED pins.

## Interface
Parameters:
- CLK_HZ, 12_000_000, input clock frequency
- TICK_HZ, 1000, tick rate (1 ms); CLK_HZ/TICK_HZ ≥ 2, integer
- CNT_W, 16, width of the dwell counter and of REMAIN
- T_START, 2000, dwell in START, in ticks (≥1)
- T_ARM, 1000, dwell in ARM, in ticks (≥1)
- T_RUN, 5000, dwell in RUN, in ticks (≥1)
- T_ABORT, 1500, SW0+SW3 hold time for abort, in ticks (≥1)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- SWITCH  in  4  debounced switches, synchronous to CLK, 0 = pressed
- LED  out  4  LED pattern
- STATE  out  3  current state encoding
- REMAIN  out  CNT_W  remaining dwell ticks minus one (0 outside timed states)
- TICK  out  1  one-CLK pulse per tick (debug)

## Operation
- All FSM, counter and edge logic updates only on CLK edges where tick=1.
- press[i] = prev[i]==1 && SWITCH[i]==0. prev is sampled every tick.
- prev resets to 4'b1111, so a switch held through reset is not a press.
- States (encoding = value driven on STATE, LED pattern):
  - IDLE=0, LED 0000: press[3] → START; load cnt=T_START-1.
  - START=1, LED 0001: cnt==0 → READY; else cnt--.
  - READY=2, LED 0011:
    - SW1==0 && SW2==0 → LOCK.
    - else press[1]|press[2] → ARM; load cnt=T_ARM-1.
  - ARM=3, LED 0011:
    - SW1==0 && SW2==0 → LOCK. This has priority over expiry.
    - else cnt==0 → RUN; load cnt=T_RUN-1.
    - else cnt--.
  - RUN=4, LED 0111:
    - SW1 && SW2 low → LOCK (priority).
    - else cnt==0 → DONE.
    - else cnt--.
  - LOCK=5, LED 1011: press[0] → CONFIRM.
  - CONFIRM=6, LED 1011: press[3] → DONE.
  - DONE=7, LED 0000: press[0] → IDLE.
- Abort, in any state except IDLE:
  - acnt counts ticks with SW0==0 && SW3==0; it clears to 0 when either switch is released.
  - When acnt reaches T_ABORT-1 with both still low, the FSM goes to IDLE, and cnt and acnt clear.
  - Abort has priority over every other transition in that tick.
  - acnt is held at 0 while in IDLE.
- Entering IDLE, READY, LOCK, CONFIRM or DONE clears cnt to 0.
- cnt saturates at 0 and never wraps.
- T_* values must fit in CNT_W; this is checked by an elaboration assertion.
- REMAIN = cnt.

## Timing
- Reset (RST_N low, async) sets:
  - STATE=IDLE, LED=0000, cnt=0, acnt=0, prev=1111;
  - prescaler=0, TICK=0.
- Reset takes effect immediately, including mid-sequence. The first tick arrives CLK_HZ/TICK_HZ cycles after RST_N deasserts.
- TICK is high for exactly one CLK every CLK_HZ/TICK_HZ cycles.
- LED and STATE are registered. They change on the same CLK edge as the state register (the tick edge), so there is zero extra latency.
- Dwell: a timed state is entered on tick k and left on tick k+T exactly.
- A press is recognised one tick after the high sample and acted on in that same tick.
- Simultaneous events in one tick are resolved in this order: abort > both-held LOCK > expiry/press.

## Structure
- Package seq_ctrl_pkg holds:
  - the state enum (3-bit, values above);
  - LED pattern constants per state;
  - switch index constants (SW_CONFIRM=0, SW_A=1, SW_B=2, SW_START=3).
- Sub-module tick_gen:
  - parameter DIV = CLK_HZ/TICK_HZ;
  - inputs CLK and RST_N; output tick;
  - modulo-DIV counter with async reset.
- Top level: edge register, dwell counter, abort counter, FSM.

## Test plan
All scenarios use CLK_HZ=4, TICK_HZ=1, T_START=3, T_ARM=2, T_RUN=4, T_ABORT=3.
- Reset and held switch:
  - SWITCH=0111 held through reset release → stays IDLE, LED=0000.
  - Release then press SW3 → START on that tick, REMAIN=2.
- Full timed path:
  - In START, REMAIN counts 2,1,0, then READY on exactly the 3rd tick.
  - Press SW1 → ARM; RUN after 2 ticks; DONE after 4 ticks; LED sequence 0001→0011→0011→0111→0000.
- Lock priority: in ARM with cnt==0, SW1 and SW2 go low in the same tick → LOCK (LED=1011), not RUN.
- Lock exit: LOCK → press SW0 → CONFIRM → press SW3 → DONE → press SW0 → IDLE. Held switches produce no repeat transitions.
- Abort:
  - In RUN, SW0 and SW3 held low for 3 ticks → IDLE, REMAIN=0.
  - Same hold released after 2 ticks → no abort, acnt clears.
- Async reset mid-RUN: RST_N pulsed low between ticks → STATE=0 and LED=0000 within the same cycle, without waiting for a CLK edge.
